// File: rtl/signed_acc_pkg.sv
// Shared types and constants for the signed accumulator slice.
package signed_acc_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/signed_acc_unit_if.sv
// Job, operand and result handshake bundle for signed_acc_unit.
interface signed_acc_unit_if
   import signed_acc_pkg::*;
#(
   parameter int unsigned LEN_W = 8
);
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_sum;
   logic              out_ovf;
   logic              busy;

   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, busy
   );

   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, busy
   );
endinterface

// File: rtl/signed_2s_comp_add.sv
// Combinational 32-bit two's-complement adder; wraps modulo 2^32, no overflow output.
module signed_2s_comp_add
   import signed_acc_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum
);
   assign sum = a + b;
endmodule

// File: rtl/signed_acc_unit.sv
// Signed streaming accumulator with sticky overflow flag and valid/ready result port.
// Define SIGNED_ACC_SAT_EN to clamp the running sum on overflow instead of wrapping.
module signed_acc_unit
   import signed_acc_pkg::*;
#(
   parameter int unsigned LEN_W = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   signed_acc_unit_if.slave bus
);

   state_t            state;
   logic [DATA_W-1:0] acc;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  len_q;
   logic              ovf;

   logic [DATA_W-1:0] add_sum;
   logic [DATA_W-1:0] next_acc;
   logic [LEN_W-1:0]  cnt_nxt;
   logic              step_ovf;
   logic              beat;

   signed_2s_comp_add u_add (
      .a   (acc),
      .b   (bus.in_data),
      .sum (add_sum)
   );

   // Like-signed operands producing an opposite-signed result is a signed overflow.
   assign step_ovf = (acc[DATA_W-1] == bus.in_data[DATA_W-1]) &&
                     (add_sum[DATA_W-1] != acc[DATA_W-1]);

`ifdef SIGNED_ACC_SAT_EN
   assign next_acc = step_ovf ? (acc[DATA_W-1] ? SAT_MIN : SAT_MAX) : add_sum;
`else
   assign next_acc = add_sum;
`endif

   assign cnt_nxt = cnt + LEN_W'(1);
   assign beat    = bus.in_valid && bus.in_ready;

   // Control and all handshake outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         len_q         <= '0;
         ovf           <= 1'b0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_ovf   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc      <= '0;
                  cnt      <= '0;
                  ovf      <= 1'b0;
                  len_q    <= bus.len;
                  bus.busy <= 1'b1;
                  if (bus.len == '0) begin
                     state         <= DONE;
                     bus.out_valid <= 1'b1;
                     bus.out_sum   <= '0;
                     bus.out_ovf   <= 1'b0;
                  end else begin
                     state        <= ACCUM;
                     bus.in_ready <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc <= next_acc;
                  cnt <= cnt_nxt;
                  if (step_ovf) ovf <= 1'b1;
                  if (cnt_nxt == len_q) begin
                     state         <= DONE;
                     bus.in_ready  <= 1'b0;
                     bus.out_valid <= 1'b1;
                     bus.out_sum   <= next_acc;
                     bus.out_ovf   <= ovf | step_ovf;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.busy      <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.in_ready  <= 1'b0;
               bus.out_valid <= 1'b0;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_acc_unit.sv
// Randomized self-checking bench for signed_acc_unit against an integer reference model.
// Honours SIGNED_ACC_SAT_EN so the model matches the build under test.
module tb_signed_acc_unit;

   localparam int unsigned LEN_W = 8;
`ifdef SIGNED_ACC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   signed_acc_unit_if #(.LEN_W(LEN_W)) bus ();

   signed_acc_unit #(.LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] ops_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // Exact integer sum with range test; wrap or clamp when it leaves 32-bit signed range.
   task automatic model(output logic [31:0] esum, output logic eovf);
      longint a = 0;
      longint t;
      eovf = 1'b0;
      foreach (ops_q[i]) begin
         t = a + longint'($signed(ops_q[i]));
         if (t > 64'sd2147483647 || t < -64'sd2147483648) begin
            eovf = 1'b1;
            if (SAT) a = (t > 0) ? 64'sd2147483647 : -64'sd2147483648;
            else     a = longint'($signed(32'(t)));
         end else begin
            a = t;
         end
      end
      esum = 32'(a);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},      32'(bus.busy),      32'd0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
   endtask

   // Runs one job from ops_q; caller is #1 after a posedge with the DUT idle.
   task automatic run_job(input bit gap, input int hold, input bit chk_lat);
      logic [31:0] esum;
      logic        eovf;
      logic [31:0] held;
      int n, idx, cyc, guard;
      n = ops_q.size();
      model(esum, eovf);
      bus.start = 1'b1;
      bus.len   = LEN_W'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1; idx = 0; guard = 0;
      while (idx < n && guard < 400) begin
         bus.in_valid = gap ? (guard % 2 == 1) : 1'b1;
         bus.in_data  = ops_q[idx];
         @(negedge clk);
         chk("in_ready_accum", 32'(bus.in_ready), 32'd1);
         @(posedge clk);
         if (bus.in_valid && bus.in_ready) idx++;
         #1; cyc++; guard++;
      end
      bus.in_valid = 1'b0;
      if (guard >= 400) chk("accept_timeout", 32'(idx), 32'(n));
      @(negedge clk);
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_sum",   bus.out_sum,        esum);
      chk("out_ovf",   32'(bus.out_ovf),   32'(eovf));
      chk("done_in_ready", 32'(bus.in_ready), 32'd0);
      if (chk_lat) chk("latency", 32'(cyc), 32'(n + 1));
      held = bus.out_sum;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b1;
         bus.len   = LEN_W'(3);
         @(negedge clk);
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_sum",   bus.out_sum,        held);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
      chk_idle("after_result");
      @(posedge clk); #1;
   endtask

   task automatic rand_ops(input int n);
      ops_q.delete();
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 3))
            0: ops_q.push_back(32'h7FFF_FFF0 + 32'($urandom_range(0, 15)));
            1: ops_q.push_back(32'h8000_0000 + 32'($urandom_range(0, 15)));
            2: ops_q.push_back(32'($signed($urandom_range(0, 2000)) - 1000));
            default: ops_q.push_back($urandom);
         endcase
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk_idle("reset");
      chk("reset_sum", bus.out_sum,      32'd0);
      chk("reset_ovf", 32'(bus.out_ovf), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      ops_q = '{32'd5, 32'hFFFF_FFFE, 32'd10};
      run_job(1'b0, 0, 1'b1);

      ops_q = '{32'h7FFF_FFFF, 32'd1};
      run_job(1'b0, 0, 1'b1);

      ops_q = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
      run_job(1'b0, 0, 1'b1);

      ops_q.delete();
      run_job(1'b0, 0, 1'b1);

      ops_q = '{32'd100, 32'hFFFF_FF00, 32'd7, 32'd3};
      run_job(1'b1, 0, 1'b0);

      ops_q = '{32'd1, 32'd2};
      run_job(1'b0, 5, 1'b1);

      // Abort mid-job with a one-cycle reset.
      bus.start = 1'b1;
      bus.len   = LEN_W'(4);
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd1000;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk_idle("mid_reset");
      chk("mid_reset_sum", bus.out_sum,      32'd0);
      chk("mid_reset_ovf", 32'(bus.out_ovf), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("no_start_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      ops_q = '{32'hFFFF_FFF9};
      run_job(1'b0, 0, 1'b1);

      for (int j = 0; j < 25; j++) begin
         rand_ops(int'($urandom_range(0, 7)));
         run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/signed_acc_unit.md
# signed_acc_unit

Sequential signed accumulator sitting directly downstream of the team's combinational 32-bit signed two's-complement adder. It consumes a stream of signed operands over a valid/ready handshake and folds each one into a running sum through that adder. It presents the final sum, with a sticky overflow flag, on a valid/ready result port. It is the reduction stage for dot-product and checksum paths.

## Interface

- LEN_W, default 8: width of the operand-count input; at most 2^LEN_W − 1 operands per job.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  LEN_W  number of operands in the job; sampled with start.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid & in_ready.
- in_data  in  32  signed operand, two's complement.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- out_sum  out  32  signed accumulated sum.
- out_ovf  out  1  sticky: signed overflow occurred during the job.
- busy  out  1  high in any state other than IDLE.

## Operation

- States:
  - IDLE: waiting for start.
  - ACCUM: accepting operands.
  - DONE: presenting the result.
- IDLE → ACCUM when start & len≠0. On this transition: acc cleared to 0, cnt to 0, ovf to 0, len latched.
- IDLE → DONE when start & len==0. Result is out_sum=0, out_ovf=0.
- ACCUM:
  - in_ready=1.
  - On each handshake: acc ← adder(acc, in_data) and cnt ← cnt+1.
  - When the accepted beat makes cnt equal to the latched len, go to DONE.
- DONE:
  - out_valid=1; out_sum=acc; out_ovf=ovf.
  - On out_ready, go to IDLE.
- start is ignored outside IDLE. in_ready=0 outside ACCUM.
- Overflow rule: if acc[31]==in_data[31] and the adder result's bit 31 differs, the step overflows and ovf is set to 1 (sticky until the next job).
- Arithmetic is 32-bit. Without saturation, the sum wraps modulo 2^32.
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- Reset asserted mid-job (synchronous) aborts the job, and the partial sum is discarded. The first operand after reset is accepted only after a new start.

## Timing

- in_ready, out_valid, busy: decoded from registered state, with no combinational path from inputs.
- out_sum and out_ovf are registered.
- start in cycle 0 → in_ready=1 from cycle 1.
- Last operand accepted in cycle k → out_valid=1 in cycle k+1, with out_sum already including that operand.
- Minimum job time with in_valid held high: len+1 cycles from start to out_valid.
- Result handshake in cycle m → busy=0 and IDLE in cycle m+1. A start in cycle m is ignored.
- out_sum and out_ovf stay stable while out_valid & !out_ready.

## Configuration

- SIGNED_ACC_SAT_EN defined:
  - An overflowing step clamps acc to 32'h7FFF_FFFF for positive overflow and 32'h8000_0000 for negative overflow.
  - Later steps continue from the clamped value.
  - ovf is still set.
- Not defined: acc takes the wrapped adder result. Overflow detection and ovf behaviour are identical.

## Structure

- Shared package signed_acc_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - localparams SAT_MAX=32'h7FFF_FFFF and SAT_MIN=32'h8000_0000.
- One sub-module: instantiate the existing signed_2s_comp_add for the acc + in_data datapath. Overflow detection and saturation logic live in this block, not in the adder.

## Test plan

- len=3, operands 5, −2, 10, out_ready=1 → out_sum=13, out_ovf=0, out_valid 4 cycles after start.
- len=2, operands 0x7FFF_FFFF, 1:
  - without macro → out_sum=0x8000_0000, out_ovf=1;
  - with SIGNED_ACC_SAT_EN → out_sum=0x7FFF_FFFF, out_ovf=1.
- len=3, operands 0x8000_0000, −1, 5 with SIGNED_ACC_SAT_EN → clamp to 0x8000_0000, then result 0x8000_0005, out_ovf=1.
- len=0 start → out_valid next cycle, out_sum=0, out_ovf=0. Also len=4 with in_valid gapped every other cycle → correct sum, and in_ready never drops in ACCUM.
- Hold out_ready=0 for 5 cycles in DONE → out_sum stable and start ignored. Then out_ready=1 → IDLE next cycle.
- rst_n low for one cycle after 2 of 4 operands → all outputs at reset values. A new job (len=1, operand −7) → out_sum=0xFFFF_FFF9, out_ovf=0.
